uart_tx_frame_ser: RTL and testbench

Parametrised UART transmit frame serializer for the TX path of the control system. It accepts a parallel word through a valid/busy handshake and produces a complete framed serial stream on a registered line output. The frame is a start bit, DATA_W data bits LSB first, an optional even/odd parity bit, and one or two stop bits. It runs on the TX bit clock, one bit per CLK cycle, and supersedes the fixed start/stop/data/parity output select.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_par_calc.sv | 17 +
 rtl/uart_tx_frame_ser.sv | 122 ++++++++++++
 tb/tb_uart_tx_frame_ser.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame serializer.
package uart_tx_pkg;

    // One state per kind of bit currently on the line.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_par_calc.sv
// Combinational parity of a data word for the selected parity type.
module uart_tx_par_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par_typ,
    output logic              par_bit
);

    // Even parity makes the total count of ones even; odd inverts it.
    always_comb begin
        par_bit = (par_typ == PAR_EVEN) ? ^data : ~^data;
    end

endmodule

// File: rtl/uart_tx_frame_ser.sv
// UART transmit frame serializer: start, DATA_W data bits LSB first,
// optional parity, one or two stop bits, one bit per CLK cycle.
module uart_tx_frame_ser
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic              TX_OUT,
    output logic              BUSY
);

    localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              par_bit_q;
    logic              stop_cnt_q;
    logic              par_bit;
    logic              accept;

    uart_tx_par_calc #(
        .DATA_W (DATA_W)
    ) u_par_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit)
    );

    // BUSY is low only in IDLE and in the last stop bit, so this is also
    // the back-to-back accept point.
    assign accept = DATA_VALID && !BUSY;

    // Frame FSM; TX_OUT and BUSY are registered from the next-state bit select.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            TX_OUT     <= STOP_BIT;
            BUSY       <= 1'b0;
        end else if (accept) begin
            state_q    <= START;
            shreg_q    <= P_DATA;
            bit_cnt_q  <= '0;
            par_en_q   <= PAR_EN;
            stop2_q    <= STOP2;
            par_bit_q  <= par_bit;
            stop_cnt_q <= 1'b0;
            TX_OUT     <= START_BIT;
            BUSY       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    TX_OUT <= STOP_BIT;
                    BUSY   <= 1'b0;
                end
                START: begin
                    state_q   <= DATA;
                    TX_OUT    <= shreg_q[0];
                    shreg_q   <= shreg_q >> 1;
                    bit_cnt_q <= '0;
                end
                DATA: begin
                    if (bit_cnt_q == CNT_LAST) begin
                        if (par_en_q) begin
                            state_q <= PARITY;
                            TX_OUT  <= par_bit_q;
                        end else begin
                            state_q    <= STOP;
                            TX_OUT     <= STOP_BIT;
                            BUSY       <= stop2_q;
                            stop_cnt_q <= 1'b0;
                        end
                    end else begin
                        TX_OUT    <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    state_q    <= STOP;
                    TX_OUT     <= STOP_BIT;
                    BUSY       <= stop2_q;
                    stop_cnt_q <= 1'b0;
                end
                STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        // Second stop bit is the last one: release BUSY now.
                        stop_cnt_q <= 1'b1;
                        TX_OUT     <= STOP_BIT;
                        BUSY       <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        TX_OUT  <= STOP_BIT;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    TX_OUT  <= STOP_BIT;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ser.sv
// Self-checking bench for uart_tx_frame_ser: a frame-level line model checked
// every cycle, plus literal frame expectations for directed words.
module tb_uart_tx_frame_ser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       dv = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic       tx, busy;

    logic [4:0] p5 = '0;
    logic [8:0] p9 = '0;
    logic       dv5 = 1'b0, dv9 = 1'b0;
    logic       tx5, busy5, tx9, busy9;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cap_w;
    int          bsy_n;

    // Line model: queue of bits still to be presented after the current one.
    bit   m_q[$];
    logic m_tx = 1'b1;
    logic m_busy = 1'b0;
    logic m_acc = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_frame_ser #(.DATA_W(8)) dut (
        .CLK (CLK), .RST (RST), .P_DATA (p_data), .DATA_VALID (dv), .PAR_EN (par_en),
        .PAR_TYP (par_typ), .STOP2 (stop2), .TX_OUT (tx), .BUSY (busy)
    );

    uart_tx_frame_ser #(.DATA_W(5)) dut5 (
        .CLK (CLK), .RST (RST), .P_DATA (p5), .DATA_VALID (dv5), .PAR_EN (par_en),
        .PAR_TYP (par_typ), .STOP2 (stop2), .TX_OUT (tx5), .BUSY (busy5)
    );

    uart_tx_frame_ser #(.DATA_W(9)) dut9 (
        .CLK (CLK), .RST (RST), .P_DATA (p9), .DATA_VALID (dv9), .PAR_EN (par_en),
        .PAR_TYP (par_typ), .STOP2 (stop2), .TX_OUT (tx9), .BUSY (busy9)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Whole-frame model: a word is taken when requested and nothing remains queued.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_q.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_acc  = 1'b0;
        end else begin
            m_acc = dv && !m_busy;
            if (m_acc) begin
                m_q.push_back(1'b0);
                for (int j = 0; j < 8; j++) m_q.push_back(p_data[j]);
                if (par_en) m_q.push_back(par_typ ? ~^p_data : ^p_data);
                m_q.push_back(1'b1);
                if (stop2) m_q.push_back(1'b1);
            end
            if (m_q.size() > 0) m_tx = m_q.pop_front();
            else m_tx = 1'b1;
            m_busy = (m_q.size() > 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("line_tx", {31'b0, tx}, {31'b0, m_tx});
        chk("line_busy", {31'b0, busy}, {31'b0, m_busy});
    end

    task automatic accept_word(input logic [7:0] d, input logic pe, input logic pt,
                               input logic s2);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        p_data = d; par_en = pe; par_typ = pt; stop2 = s2; dv = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(posedge CLK);
            #1;
            ok = m_acc;
        end
        dv = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        cap_w    = '0;
        cap_w[0] = tx;
        bsy_n    = int'(busy);
    endtask

    // Sample positions 1..n-1 of the frame started by accept_word.
    task automatic capture(input int n);
        for (int i = 1; i < n; i++) begin
            @(posedge CLK);
            #1;
            cap_w[i] = tx;
            bsy_n += int'(busy);
        end
    endtask

    initial begin
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_tx5", {31'b0, tx5}, 32'd1);
        chk("rst_tx9", {31'b0, tx9}, 32'd1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1 then idle 1.
        accept_word(8'hA5, 1'b0, 1'b0, 1'b0);
        capture(11);
        chk("a5_frame", cap_w, 32'h74A);
        chk("a5_busy_cycles", bsy_n, 32'd9);

        // 0x07 even parity: parity bit 1 at position 9, F=11.
        accept_word(8'h07, 1'b1, 1'b0, 1'b0);
        capture(12);
        chk("p07_even_frame", cap_w, 32'hE0E);
        chk("p07_even_parity", {31'b0, cap_w[9]}, 32'd1);
        chk("p07_even_busy", bsy_n, 32'd10);

        // 0x07 odd parity: parity bit 0.
        accept_word(8'h07, 1'b1, 1'b1, 1'b0);
        capture(12);
        chk("p07_odd_frame", cap_w, 32'hC0E);
        chk("p07_odd_parity", {31'b0, cap_w[9]}, 32'd0);

        // Back-to-back 0x3C then 0xC3 with parity and two stop bits.
        accept_word(8'h3C, 1'b1, 1'b0, 1'b1);
        p_data = 8'hC3;
        dv     = 1'b1;
        capture(13);
        dv = 1'b0;
        chk("b2b_frame", cap_w & 32'h0FFF, 32'hC78);
        chk("b2b_start", {31'b0, cap_w[12]}, 32'd0);
        chk("b2b_accepted", {31'b0, m_acc}, 32'd1);
        repeat (14) @(negedge CLK);

        // 0x5A with a mid-frame 0xFF request and parity type flip, both ignored.
        accept_word(8'h5A, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) begin
            @(posedge CLK);
            #1;
            cap_w[i] = tx;
            bsy_n += int'(busy);
            if (i == 3) begin
                dv = 1'b1; p_data = 8'hFF; par_typ = 1'b1;
            end
            if (i == 5) begin
                dv = 1'b0; par_typ = 1'b0;
            end
        end
        chk("ignore_frame", cap_w, 32'hCB4);
        chk("ignore_busy", bsy_n, 32'd10);

        // Reset during data bit 4 of 0x55, then a clean 0x55 frame.
        accept_word(8'h55, 1'b0, 1'b0, 1'b0);
        capture(6);
        #2 RST = 1'b0;
        #1;
        chk("midrst_tx", {31'b0, tx}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        accept_word(8'h55, 1'b0, 1'b0, 1'b0);
        capture(11);
        chk("post_rst_frame", cap_w, 32'h6AA);

        // DATA_W=5 and DATA_W=9, all ones, even parity, one stop.
        @(negedge CLK);
        p5 = 5'h1F; p9 = 9'h1FF; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        dv5 = 1'b1; dv9 = 1'b1;
        begin
            logic [31:0] w5, w9;
            int          b5, b9;
            @(posedge CLK);
            #1;
            dv5 = 1'b0; dv9 = 1'b0;
            w5 = '0; w9 = '0;
            w5[0] = tx5; w9[0] = tx9;
            b5 = int'(busy5); b9 = int'(busy9);
            for (int i = 1; i < 14; i++) begin
                @(posedge CLK);
                #1;
                w5[i] = tx5; w9[i] = tx9;
                b5 += int'(busy5); b9 += int'(busy9);
            end
            chk("w5_frame", w5, 32'h3FFE);
            chk("w5_busy_cycles", b5, 32'd7);
            chk("w9_frame", w9, 32'h3FFE);
            chk("w9_busy_cycles", b9, 32'd11);
        end

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
